// File: rtl/lsu_wb.sv
// Load/store unit bus master: one CPU load/store becomes one classic Wishbone cycle,
// with lane select, write-data replication, read alignment/extension, misalign and timeout.
module lsu_wb #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   output logic        o_ready,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_err_misalign,
   output logic        o_err_timeout,
   output logic [31:0] o_wb_addr,
   output logic        o_wb_stb,
   output logic        o_wb_cyc,
   output logic        o_wb_we,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_wdata,
   input  logic        i_wb_ack,
   input  logic [31:0] i_wb_rdata
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [1:0]      lo_q, lo_d;
   logic            cyc_q, cyc_d;
   logic            wb_we_q, wb_we_d;
   logic [31:0]     wb_addr_q, wb_addr_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            mis_q, mis_d;
   logic            tmo_q, tmo_d;

   logic            accept;
   logic            misalign;
   logic [3:0]      sel_calc;
   logic [31:0]     wdata_calc;
   logic [31:0]     shifted;
   logic [31:0]     load_ext;

   assign o_ready        = (state_q == StIdle) & ~i_reset;
   assign o_done         = (state_q == StResp);
   assign o_rdata        = rdata_q;
   assign o_err_misalign = mis_q;
   assign o_err_timeout  = tmo_q;
   assign o_wb_addr      = wb_addr_q;
   assign o_wb_stb       = cyc_q;
   assign o_wb_cyc       = cyc_q;
   assign o_wb_we        = wb_we_q;
   assign o_wb_sel       = sel_q;
   assign o_wb_wdata     = wdata_q;

   assign accept   = i_req & o_ready;
   assign misalign = ((i_size == 2'd1) & i_addr[0]) |
                     ((i_size == 2'd2) & (i_addr[1:0] != 2'b00)) |
                     (i_size == 2'd3);

   always_comb begin
      sel_calc   = 4'b1111;
      wdata_calc = i_wdata;
      case (i_size)
         2'd0: begin
            sel_calc   = 4'b0001 << i_addr[1:0];
            wdata_calc = {4{i_wdata[7:0]}};
         end
         2'd1: begin
            sel_calc   = 4'b0011 << i_addr[1:0];
            wdata_calc = {2{i_wdata[15:0]}};
         end
         default: begin
            sel_calc   = 4'b1111;
            wdata_calc = i_wdata;
         end
      endcase
   end

   // Selected lanes are moved down to bit 0 before extension.
   assign shifted = i_wb_rdata >> {lo_q, 3'b000};

   always_comb begin
      load_ext = shifted;
      case (size_q)
         2'd0:    load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         2'd1:    load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      size_d    = size_q;
      uns_d     = uns_q;
      lo_d      = lo_q;
      cyc_d     = cyc_q;
      wb_we_d   = wb_we_q;
      wb_addr_d = wb_addr_q;
      sel_d     = sel_q;
      wdata_d   = wdata_q;
      rdata_d   = 32'h0;
      mis_d     = 1'b0;
      tmo_d     = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               we_d   = i_we;
               size_d = i_size;
               uns_d  = i_unsigned;
               lo_d   = i_addr[1:0];
               if (misalign) begin
                  mis_d   = 1'b1;
                  state_d = StResp;
               end else begin
                  cyc_d     = 1'b1;
                  wb_we_d   = i_we;
                  wb_addr_d = {i_addr[31:2], 2'b00};
                  sel_d     = sel_calc;
                  wdata_d   = wdata_calc;
                  cnt_d     = '0;
                  state_d   = StBus;
               end
            end
         end
         StBus: begin
            // Ack is tested first so it wins over the timeout limit in the same cycle.
            if (i_wb_ack) begin
               cyc_d   = 1'b0;
               rdata_d = we_q ? 32'h0 : load_ext;
               state_d = StResp;
            end else if (cnt_q == CntLast) begin
               cyc_d   = 1'b0;
               tmo_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         size_q    <= 2'd0;
         uns_q     <= 1'b0;
         lo_q      <= 2'd0;
         cyc_q     <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= 32'h0;
         sel_q     <= 4'h0;
         wdata_q   <= 32'h0;
         rdata_q   <= 32'h0;
         mis_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         lo_q      <= lo_d;
         cyc_q     <= cyc_d;
         wb_we_q   <= wb_we_d;
         wb_addr_q <= wb_addr_d;
         sel_q     <= sel_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         mis_q     <= mis_d;
         tmo_q     <= tmo_d;
      end
   end

endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: byte-array memory model plus expectation queue checked every cycle,
// a configurable-latency Wishbone slave, and literal pins on key results.
module tb_lsu_wb;

   localparam int T = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_we, i_unsigned;
   logic [31:0] i_addr, i_wdata;
   logic [1:0]  i_size;
   logic        o_ready, o_done, o_err_misalign, o_err_timeout;
   logic [31:0] o_rdata, o_wb_addr, o_wb_wdata;
   logic        o_wb_stb, o_wb_cyc, o_wb_we;
   logic [3:0]  o_wb_sel;
   logic        wb_ack;
   logic [31:0] wb_rdata;

   always #5 clk = ~clk;

   lsu_wb #(.TIMEOUT_CYCLES(T)) dut (
      .i_clk(clk), .i_reset(rst), .i_req(i_req), .o_ready(o_ready), .i_we(i_we),
      .i_addr(i_addr), .i_size(i_size), .i_unsigned(i_unsigned), .i_wdata(i_wdata),
      .o_done(o_done), .o_rdata(o_rdata), .o_err_misalign(o_err_misalign),
      .o_err_timeout(o_err_timeout), .o_wb_addr(o_wb_addr), .o_wb_stb(o_wb_stb),
      .o_wb_cyc(o_wb_cyc), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel), .o_wb_wdata(o_wb_wdata),
      .i_wb_ack(wb_ack), .i_wb_rdata(wb_rdata)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc_cnt = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      return 32'h11223344 + 32'h01010101 * i;
   endfunction

   // Slave: acks slv_delay cycles after first seeing stb&cyc, keeps acking while held.
   logic [31:0] slv_mem [64];
   bit          slv_en = 1'b1;
   int          slv_delay = 0;
   int          wcnt;

   always @(posedge clk) begin
      if (rst) begin
         wb_ack <= 1'b0;
         wcnt   <= 0;
         for (int i = 0; i < 64; i++) slv_mem[i] <= init_word(i);
      end else if (o_wb_cyc && o_wb_stb && slv_en) begin
         if (wcnt >= slv_delay) begin
            wb_ack   <= 1'b1;
            wb_rdata <= slv_mem[o_wb_addr[7:2]];
            if (o_wb_we)
               for (int k = 0; k < 4; k++)
                  if (o_wb_sel[k]) slv_mem[o_wb_addr[7:2]][8*k +: 8] <= o_wb_wdata[8*k +: 8];
         end else begin
            wb_ack <= 1'b0;
            wcnt   <= wcnt + 1;
         end
      end else begin
         wb_ack <= 1'b0;
         wcnt   <= 0;
      end
   end

   // Model state
   logic [7:0] mdl [256];

   typedef struct {
      logic [31:0] rdata;
      bit          mis;
      bit          tmo;
      int          done_at;
      int          cyc_from;
      int          cyc_to;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] addr;
      bit          we;
   } exp_t;

   exp_t        q[$];
   logic [31:0] last_rdata, last_wdata;
   logic [3:0]  last_sel;
   bit          last_mis, last_tmo;
   int          last_acc, last_done;

   task automatic mdl_reset();
      logic [31:0] w;
      for (int i = 0; i < 64; i++) begin
         w = init_word(i);
         for (int k = 0; k < 4; k++) mdl[4*i+k] = w[8*k +: 8];
      end
   endtask

   // Per-cycle compare against the head expectation.
   bit exp_cyc, exp_done;
   always @(negedge clk) begin
      if (!rst) begin
         exp_cyc  = (q.size() > 0) && cyc_cnt >= q[0].cyc_from && cyc_cnt <= q[0].cyc_to;
         exp_done = (q.size() > 0) && cyc_cnt == q[0].done_at;
         chk("wb_cyc", o_wb_cyc, exp_cyc);
         chk("wb_stb", o_wb_stb, exp_cyc);
         if (exp_cyc) begin
            chk("wb_addr", o_wb_addr, q[0].addr);
            chk("wb_sel", o_wb_sel, q[0].sel);
            chk("wb_we", o_wb_we, q[0].we);
            if (q[0].we) chk("wb_wdata", o_wb_wdata, q[0].wdata);
         end
         chk("done", o_done, exp_done);
         if (exp_done) begin
            chk("rdata", o_rdata, q[0].rdata);
            chk("err_misalign", o_err_misalign, q[0].mis);
            chk("err_timeout", o_err_timeout, q[0].tmo);
            last_rdata = o_rdata;
            last_mis   = o_err_misalign;
            last_tmo   = o_err_timeout;
            last_done  = cyc_cnt;
            void'(q.pop_front());
         end else begin
            chk("rdata_idle", o_rdata, 32'h0);
            chk("flags_idle", {o_err_misalign, o_err_timeout}, 2'b00);
         end
      end
   end

   task automatic build_exp(input bit we, input logic [31:0] addr, input logic [1:0] size,
                            input bit uns, input logic [31:0] wd, input int acc, output exp_t e);
      int n, a;
      logic [31:0] v;
      n = 1 << size;
      a = int'(addr[7:0]);
      e.addr = addr & 32'hFFFF_FFFC;
      e.we = we;
      e.mis = (size == 2'd3) || (a % n != 0);
      e.tmo = 1'b0;
      e.rdata = 32'h0;
      for (int k = 0; k < 4; k++) begin
         e.sel[k] = (k >= a % 4) && (k < a % 4 + n);
         e.wdata[8*k +: 8] = wd[8*(k % n) +: 8];
      end
      if (e.mis) begin
         e.done_at = acc; e.cyc_from = 1; e.cyc_to = 0;
      end else if (slv_en && slv_delay + 2 <= T) begin
         e.done_at = acc + 2 + slv_delay; e.cyc_from = acc; e.cyc_to = acc + 1 + slv_delay;
         if (we) begin
            for (int i = 0; i < n; i++) mdl[a+i] = wd[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a+i];
            if (!uns && n < 4 && v[8*n-1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
            e.rdata = v;
         end
      end else begin
         e.tmo = 1'b1; e.done_at = acc + T; e.cyc_from = acc; e.cyc_to = acc + T - 1;
      end
   endtask

   task automatic issue(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wd, output int acc);
      exp_t e;
      int waited;
      @(negedge clk);
      i_req = 1'b1; i_we = we; i_addr = addr; i_size = size; i_unsigned = uns; i_wdata = wd;
      waited = 0;
      while (!o_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!o_ready) chk("ready_wait", 32'(o_ready), 32'h1);
      @(posedge clk);
      #1;
      acc = cyc_cnt;
      i_req = 1'b0;
      last_acc = acc;
      last_sel = o_wb_sel;
      last_wdata = o_wb_wdata;
      build_exp(we, addr, size, uns, wd, acc, e);
      q.push_back(e);
   endtask

   task automatic access(input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wd);
      int acc, waited;
      issue(we, addr, size, uns, wd, acc);
      waited = 0;
      while (q.size() != 0 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (q.size() != 0) begin
         chk("done_wait", 32'(q.size()), 32'h0);
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int acc;
   initial begin
      rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_size = '0; i_unsigned = 1'b0;
      i_wdata = '0;
      mdl_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 32'(o_ready), 32'h0);
      chk("reset_outs", {o_done, o_err_misalign, o_err_timeout, o_wb_stb, o_wb_cyc, o_wb_we},
          32'h0);
      chk("reset_rdata", o_rdata, 32'h0);
      chk("reset_sel", 32'(o_wb_sel), 32'h0);
      chk("reset_addr", o_wb_addr, 32'h0);
      chk("reset_wdata", o_wb_wdata, 32'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 32'(o_ready), 32'h1);

      // Word store then load, 1-cycle ack: done two cycles after the accept cycle.
      access(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
      chk("lit_word_sel", 32'(last_sel), 32'hF);
      access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      chk("lit_word_load", last_rdata, 32'hDEADBEEF);
      chk("lit_bus_latency", 32'(last_done - last_acc), 32'd2);

      access(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000A5);
      chk("lit_byte_sel", 32'(last_sel), 32'h8);
      chk("lit_byte_wdata", last_wdata, 32'hA5A5A5A5);
      access(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
      chk("lit_byte_signed", last_rdata, 32'hFFFFFFA5);
      access(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
      chk("lit_byte_unsigned", last_rdata, 32'h000000A5);

      access(1'b1, 32'h22, 2'd1, 1'b0, 32'h00008001);
      chk("lit_half_sel", 32'(last_sel), 32'hC);
      chk("lit_half_mem", slv_mem[8], 32'h80013B4C);
      access(1'b0, 32'h22, 2'd1, 1'b0, 32'h0);
      chk("lit_half_signed", last_rdata, 32'hFFFF8001);
      access(1'b0, 32'h22, 2'd1, 1'b1, 32'h0);

      for (int a = 32'h10; a < 32'h14; a++) access(1'b0, 32'(a), 2'd0, 1'b0, 32'h0);
      access(1'b0, 32'h20, 2'd1, 1'b0, 32'h0);

      // Misaligned accesses: no bus cycle, done in the cycle right after accept.
      access(1'b0, 32'h21, 2'd1, 1'b0, 32'h0);
      chk("lit_mis_half", 32'(last_mis), 32'h1);
      chk("lit_mis_latency", 32'(last_done - last_acc), 32'd0);
      access(1'b0, 32'h22, 2'd2, 1'b0, 32'h0);
      access(1'b1, 32'h20, 2'd3, 1'b0, 32'h12345678);
      chk("lit_mis_size3", 32'(last_mis), 32'h1);

      // Slave that never acks.
      slv_en = 1'b0;
      access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      chk("lit_timeout", 32'(last_tmo), 32'h1);
      chk("lit_timeout_latency", 32'(last_done - last_acc), 32'(T));
      slv_en = 1'b1;
      access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      chk("lit_after_timeout", last_rdata, 32'hA5ADBEEF);

      // Late ack one cycle past the limit (ignored in RESP), then ack exactly at the limit.
      slv_delay = T - 1;
      access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      slv_delay = T - 2;
      access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      chk("lit_ack_at_limit", last_rdata, 32'hA5ADBEEF);
      chk("lit_ack_limit_tmo", 32'(last_tmo), 32'h0);
      slv_delay = 0;

      // Reset while the bus cycle is outstanding.
      slv_en = 1'b0;
      issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, acc);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      mdl_reset();
      chk("rst_cyc", 32'({o_wb_cyc, o_wb_stb}), 32'h0);
      chk("rst_done", 32'(o_done), 32'h0);
      chk("rst_ready", 32'(o_ready), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_release_ready", 32'(o_ready), 32'h1);
      slv_en = 1'b1;
      repeat (4) @(posedge clk);
      access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      chk("lit_after_reset", last_rdata, 32'h15263748);
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/store unit bus master. Accepts one CPU load or store request at a time and converts it into a single classic Wishbone cycle toward the tightly-coupled memory or interconnect. Generates byte-lane selects and replicated write data, waits for the acknowledge, then aligns and sign- or zero-extends read data. Flags misaligned accesses without touching the bus, and aborts a cycle that is never acknowledged.

## Interface
- TIMEOUT_CYCLES, 15: BUS-state cycles without ack before abort (≥2)
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req  in  1  request valid; accepted when i_req & o_ready
- o_ready  out  1  unit idle, can accept
- i_we  in  1  1 = store, 0 = load
- i_addr  in  32  byte address
- i_size  in  2  0 byte, 1 half, 2 word, 3 reserved
- i_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- i_wdata  in  32  store data, right-aligned
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  extended load data, valid with o_done
- o_err_misalign  out  1  valid with o_done
- o_err_timeout  out  1  valid with o_done
- o_wb_addr  out  32  {addr[31:2],2'b00}
- o_wb_stb, o_wb_cyc, o_wb_we  out  1 each
- o_wb_sel  out  4  byte lanes
- o_wb_wdata  out  32  lane-replicated data
- i_wb_ack  in  1
- i_wb_rdata  in  32

## Operation
- States: IDLE, BUS, RESP. o_ready = (state==IDLE) & ~i_reset.
- IDLE, on accept: latch we, addr, size, unsigned. Misaligned = (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | size==3.
  - Misaligned: go RESP with misalign flag; no bus activity.
  - Else: register o_wb_cyc=o_wb_stb=1, o_wb_we, o_wb_addr, o_wb_sel, o_wb_wdata; clear timeout counter; go BUS.
- Lane select: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- BUS: on i_wb_ack, deassert cyc/stb at that edge, capture i_wb_rdata shifted right by addr[1:0]*8, go RESP. Otherwise increment counter; when counter reaches TIMEOUT_CYCLES-1 without ack, deassert cyc/stb, set timeout flag, go RESP.
- Load extension: byte bit 7, half bit 15 replicated into upper bits when i_unsigned=0, zeros otherwise; word unchanged.
- RESP: o_done=1 for exactly one cycle with o_rdata and error flags; go IDLE. Stores, misaligned and timed-out accesses report o_rdata=0.
- i_wb_ack outside BUS is ignored (a slave that acks every cycle stb&cyc is held produces one trailing ack in RESP; it is discarded).
- Flags mutually exclusive; both 0 on success. Outputs other than o_rdata/flags are don't-care-free: o_rdata and flags are 0 whenever o_done=0.

## Timing
- Reset: state IDLE; o_done, o_rdata, both flags, o_wb_stb, o_wb_cyc, o_wb_we, o_wb_sel, o_wb_addr, o_wb_wdata, counter all 0.
- Reset mid-cycle: cyc/stb low at next edge, no o_done emitted for the aborted request.
- Accept at edge N: stb/cyc high from N+1. Slave with 1-cycle registered ack: ack visible cycle N+2, o_done cycle N+3, o_ready cycle N+4. Sustained throughput 1 access / 4 cycles.
- Misaligned: accept N, o_done N+1, o_ready N+2.
- Timeout: cyc/stb high exactly TIMEOUT_CYCLES cycles, o_done the cycle after they drop.
- i_req while o_ready=0 is not accepted; requester holds it.
- Ack in the same cycle the counter hits the limit: ack wins, normal completion.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10 against 1-cycle-ack memory -> sel 4'b1111, o_done at N+3, o_rdata 0xDEADBEEF, flags 0.
- Byte store 0xA5 to 0x13 -> sel 4'b1000, wdata 0xA5A5A5A5; signed byte load 0x13 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
- Half store 0x8001 to 0x22 -> sel 4'b1100; signed half load 0x22 -> 0xFFFF8001; memory word 0x8001xxxx with other bytes intact.
- Half load at 0x21 and word load at 0x22, size 3 at 0x20 -> o_done at N+1, o_err_misalign=1, o_wb_cyc never asserted.
- Slave never acks, TIMEOUT_CYCLES=15 -> stb high 15 cycles, then o_done with o_err_timeout=1; following request completes normally.
- Assert i_reset while in BUS -> cyc/stb 0 next cycle, no o_done, o_ready=1 after reset release; ack arriving in RESP is ignored (single o_done only).
